t48_exp8243: RTL and testbench

Synchronous model of the 8243 I/O expander, consuming the T48 P2 lower nibble and PROG strobe. Latches a 4-bit command on the PROG falling edge, transfers one nibble on the PROG rising edge, and manages four 4-bit expander ports (P4–P7). All logic runs on the system clock; PROG edges are detected by sampling, not used as clocks.

---
 rtl/t48_exp8243.sv | 131 +++++++++++++
 tb/tb_t48_exp8243.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/t48_exp8243.sv
// rtl/t48_exp8243.sv - 8243 I/O expander model driven by T48 P2[3:0] and PROG (optional T48_EXP8243_SYNC_EN input synchronizer)
module t48_exp8243 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cs_n_i,
   input  logic        prog_i,
   input  logic [3:0]  p2_i,
   output logic [3:0]  p2_o,
   output logic        p2_oe_o,
   input  logic [15:0] port_i,
   output logic [15:0] port_o,
   output logic [3:0]  port_oe_o
);

   typedef enum logic {ST_IDLE, ST_XFER} state_t;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_OR    = 2'b10;
   localparam logic [1:0] OP_AND   = 2'b11;

   logic       w_prog;
   logic       w_cs_n;
   logic [3:0] w_p2;

`ifdef T48_EXP8243_SYNC_EN
   logic [1:0] r_prog_s;
   logic [1:0] r_cs_s;
   logic [3:0] r_p2_s1;
   logic [3:0] r_p2_s2;

   // Two-flop synchronizers for the asynchronous T48 bus signals
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_prog_s <= 2'b11;
         r_cs_s   <= 2'b11;
         r_p2_s1  <= 4'h0;
         r_p2_s2  <= 4'h0;
      end else begin
         r_prog_s <= {r_prog_s[0], prog_i};
         r_cs_s   <= {r_cs_s[0], cs_n_i};
         r_p2_s1  <= p2_i;
         r_p2_s2  <= r_p2_s1;
      end
   end

   assign w_prog = r_prog_s[1];
   assign w_cs_n = r_cs_s[1];
   assign w_p2   = r_p2_s2;
`else
   assign w_prog = prog_i;
   assign w_cs_n = cs_n_i;
   assign w_p2   = p2_i;
`endif

   state_t      r_state;
   logic        r_prog_q;
   logic [1:0]  r_op;
   logic [1:0]  r_k;
   logic [15:0] r_port;
   logic [3:0]  r_port_oe;
   logic [3:0]  r_p2_o;
   logic        r_p2_oe;

   logic       w_fall;
   logic       w_rise;
   logic [3:0] w_cur_nib;
   logic [3:0] w_pin_k;
   logic [3:0] w_pin_cmd;

   assign w_fall    = r_prog_q & ~w_prog;
   assign w_rise    = ~r_prog_q & w_prog;
   assign w_cur_nib = r_port[{r_k, 2'b00} +: 4];
   assign w_pin_k   = port_i[{r_k, 2'b00} +: 4];
   assign w_pin_cmd = port_i[{w_p2[1:0], 2'b00} +: 4];

   // Command/transfer FSM; all outputs are registered here
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_prog_q  <= 1'b1;
         r_op      <= OP_READ;
         r_k       <= 2'b00;
         r_port    <= 16'h0000;
         r_port_oe <= 4'b0000;
         r_p2_o    <= 4'h0;
         r_p2_oe   <= 1'b0;
      end else begin
         r_prog_q <= w_prog;
         case (r_state)
            ST_IDLE: begin
               if (w_fall && !w_cs_n) begin
                  r_op    <= w_p2[3:2];
                  r_k     <= w_p2[1:0];
                  r_state <= ST_XFER;
                  if (w_p2[3:2] == OP_READ) begin
                     r_port_oe[w_p2[1:0]] <= 1'b0;
                     r_p2_oe              <= 1'b1;
                     r_p2_o               <= w_pin_cmd;
                  end
               end
            end
            ST_XFER: begin
               if (w_rise) begin
                  case (r_op)
                     OP_WRITE: r_port[{r_k, 2'b00} +: 4] <= w_p2;
                     OP_OR:    r_port[{r_k, 2'b00} +: 4] <= w_cur_nib | w_p2;
                     OP_AND:   r_port[{r_k, 2'b00} +: 4] <= w_cur_nib & w_p2;
                     default:  r_port <= r_port;
                  endcase
                  if (r_op != OP_READ) begin
                     r_port_oe[r_k] <= 1'b1;
                  end
                  r_p2_oe <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_op == OP_READ) begin
                  // Live read: follow the pins while PROG is low
                  r_p2_o <= w_pin_k;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign p2_o      = r_p2_o;
   assign p2_oe_o   = r_p2_oe;
   assign port_o    = r_port;
   assign port_oe_o = r_port_oe;

endmodule

// File: tb/tb_t48_exp8243.sv
// tb/tb_t48_exp8243.sv - randomized self-checking bench for t48_exp8243 against a nibble-array model
module tb_t48_exp8243;

`ifdef T48_EXP8243_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cs_n_i = 1'b1;
   logic        prog_i = 1'b1;
   logic [3:0]  p2_i = 4'h0;
   logic [3:0]  p2_o;
   logic        p2_oe_o;
   logic [15:0] port_i = 16'h0000;
   logic [15:0] port_o;
   logic [3:0]  port_oe_o;

   int n_chk = 0;
   int n_fail = 0;

   logic [3:0] m_port [4];
   logic [3:0] m_oe;

   t48_exp8243 dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .cs_n_i    (cs_n_i),
      .prog_i    (prog_i),
      .p2_i      (p2_i),
      .p2_o      (p2_o),
      .p2_oe_o   (p2_oe_o),
      .port_i    (port_i),
      .port_o    (port_o),
      .port_oe_o (port_oe_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [15:0] m_port_flat();
      return {m_port[3], m_port[2], m_port[1], m_port[0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_port[i] = 4'h0;
      m_oe = 4'b0000;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // One full PROG transaction with inline checks; low = extra PROG-low cycles after capture
   task automatic run_txn(input logic [1:0] op, input logic [1:0] k, input logic [3:0] data,
                          input logic cs, input int low, input string tag);
      logic [3:0] pin;
      logic       active;
      active = !cs;
      prog_i = 1'b0;
      p2_i   = {op, k};
      cs_n_i = cs;
      tick(LAT + 1);
      if (active && op == 2'b00) m_oe[k] = 1'b0;
      pin = port_i[k*4 +: 4];
      n_chk++;
      if (p2_oe_o !== (active && op == 2'b00)) begin
         n_fail++;
         $display("FAIL %s p2_oe_at_fall got %b want %b", tag, p2_oe_o, (active && op == 2'b00));
      end
      if (active && op == 2'b00) begin
         n_chk++;
         if (p2_o !== pin || port_oe_o !== m_oe) begin
            n_fail++;
            $display("FAIL %s read_turnaround got p2_o=%h oe=%b want p2_o=%h oe=%b", tag, p2_o, port_oe_o, pin, m_oe);
         end
      end
      p2_i = data;
      if (low >= 2) begin
         port_i[k*4 +: 4] = 4'($urandom);
         pin = port_i[k*4 +: 4];
         tick(1);
         if (active && op == 2'b00) begin
            n_chk++;
            if (p2_o !== pin) begin
               n_fail++;
               $display("FAIL %s live_read got %h want %h", tag, p2_o, pin);
            end
         end
         tick(low - 2);
      end
      prog_i = 1'b1;
      tick(LAT + 1);
      if (active) begin
         case (op)
            2'b01: begin m_port[k] = data;             m_oe[k] = 1'b1; end
            2'b10: begin m_port[k] = m_port[k] | data; m_oe[k] = 1'b1; end
            2'b11: begin m_port[k] = m_port[k] & data; m_oe[k] = 1'b1; end
            default: ;
         endcase
      end
      n_chk++;
      if (port_o !== m_port_flat() || port_oe_o !== m_oe || p2_oe_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_rise got port=%h oe=%b p2_oe=%b want port=%h oe=%b p2_oe=0",
                  tag, port_o, port_oe_o, p2_oe_o, m_port_flat(), m_oe);
      end
      cs_n_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      model_reset();
      tick(2);
      n_chk++;
      if (port_o !== 16'h0 || port_oe_o !== 4'b0 || p2_oe_o !== 1'b0 || p2_o !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_state got port=%h oe=%b p2_oe=%b p2_o=%h want 0000 0000 0 0", port_o, port_oe_o, p2_oe_o, p2_o);
      end
      rst_i = 1'b0;
      tick(1);
   endtask

   task automatic test_write_or_and();
      run_txn(2'b01, 2'd1, 4'hA, 1'b0, 1, "write_p5");
      n_chk++;
      if (port_o[7:4] !== 4'hA || port_oe_o !== 4'b0010) begin
         n_fail++;
         $display("FAIL write_p5_const got %h/%b want A/0010", port_o[7:4], port_oe_o);
      end
      run_txn(2'b10, 2'd1, 4'h5, 1'b0, 2, "or_p5");
      n_chk++;
      if (port_o[7:4] !== 4'hF) begin
         n_fail++;
         $display("FAIL or_p5_const got %h want F", port_o[7:4]);
      end
      run_txn(2'b11, 2'd1, 4'h6, 1'b0, 1, "and_p5");
      n_chk++;
      if (port_o[7:4] !== 4'h6) begin
         n_fail++;
         $display("FAIL and_p5_const got %h want 6", port_o[7:4]);
      end
   endtask

   task automatic test_read();
      run_txn(2'b01, 2'd3, 4'hC, 1'b0, 1, "write_p7");
      port_i[15:12] = 4'h3;
      run_txn(2'b00, 2'd3, 4'h0, 1'b0, 3, "read_p7");
      n_chk++;
      if (port_oe_o[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL read_p7_oe got %b want 0", port_oe_o[3]);
      end
   endtask

   task automatic test_cs_n();
      run_txn(2'b01, 2'd2, 4'h9, 1'b1, 2, "cs_high_write");
      run_txn(2'b00, 2'd0, 4'h0, 1'b1, 1, "cs_high_read");
   endtask

   task automatic test_async_reset();
      run_txn(2'b01, 2'd0, 4'h7, 1'b0, 1, "pre_reset_write");
      #3 rst_i = 1'b1;
      #1;
      model_reset();
      n_chk++;
      if (port_o !== 16'h0 || port_oe_o !== 4'b0 || p2_oe_o !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got port=%h oe=%b p2_oe=%b want 0000 0000 0", port_o, port_oe_o, p2_oe_o);
      end
      tick(1);
      rst_i = 1'b0;
      tick(1);
   endtask

   task automatic test_reset_in_xfer();
      prog_i = 1'b0;
      p2_i   = 4'b0110;
      cs_n_i = 1'b0;
      tick(LAT + 1);
      p2_i  = 4'hB;
      rst_i = 1'b1;
      #1;
      n_chk++;
      if (p2_oe_o !== 1'b0 || port_o !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_in_xfer_now got p2_oe=%b port=%h want 0 0000", p2_oe_o, port_o);
      end
      prog_i = 1'b1;
      cs_n_i = 1'b1;
      tick(LAT + 2);
      rst_i = 1'b0;
      tick(LAT + 2);
      model_reset();
      n_chk++;
      if (port_o !== 16'h0 || port_oe_o !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_in_xfer_after got port=%h oe=%b want 0000 0000", port_o, port_oe_o);
      end
      run_txn(2'b01, 2'd2, 4'hD, 1'b0, 1, "post_reset_write");
   endtask

   task automatic test_back_to_back_random();
      for (int i = 0; i < 60; i++) begin
         port_i = 16'($urandom);
         run_txn(2'($urandom), 2'($urandom), 4'($urandom), ($urandom_range(3, 0) == 0),
                 $urandom_range(3, 1), "random");
      end
   endtask

   initial begin
      model_reset();
      tick(1);
      test_reset();
      test_write_or_and();
      test_read();
      test_cs_n();
      test_async_reset();
      test_reset_in_xfer();
      test_back_to_back_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
